// File: rtl/cgol_pkg.sv
// Shared types and sizes for the 8x8 Game-of-Life board controller.
package cgol_pkg;

    localparam int BOARD_N = 8;
    localparam int ROW_W   = 3;

    typedef logic [BOARD_N-1:0] row_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_PRE,
        U_ROW,
        U_DONE
    } upd_state_t;

endpackage

// File: rtl/cgol_row_rule.sv
// Next-generation value for one board row, given the rows above and below.
// Columns wrap, so column 0 and column 7 are neighbours.
module cgol_row_rule
    import cgol_pkg::*;
(
    input  row_t prev,
    input  row_t cur,
    input  row_t below,
    output row_t next
);

    logic [3:0] n;

    // Count the eight toroidal neighbours of each column and apply the rule.
    always_comb begin
        next = '0;
        n    = '0;
        for (int unsigned i = 0; i < BOARD_N; i++) begin
            n = {3'b000, prev[(i + BOARD_N - 1) % BOARD_N]}
              + {3'b000, prev[i]}
              + {3'b000, prev[(i + 1) % BOARD_N]}
              + {3'b000, cur[(i + BOARD_N - 1) % BOARD_N]}
              + {3'b000, cur[(i + 1) % BOARD_N]}
              + {3'b000, below[(i + BOARD_N - 1) % BOARD_N]}
              + {3'b000, below[i]}
              + {3'b000, below[(i + 1) % BOARD_N]};
            next[i] = (n == 4'd3) || (cur[i] && (n == 4'd2));
        end
    end

endmodule

// File: rtl/cgol_gen_sched.sv
// Game-of-Life board controller: display row scanner, read-port arbiter
// (display always wins), generation-update engine and pattern-load path.
module cgol_gen_sched
    import cgol_pkg::*;
#(
    parameter int DWELL          = 4,
    parameter int FRAMES_PER_GEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic       load_valid,
    input  logic [2:0] load_row,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [2:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic [2:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       busy,
    output logic [15:0] gen_count
);

    localparam int DW = $clog2(DWELL);
    localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_GEN - 1);

    // Scanner state
    logic [DW-1:0]    dcnt;
    logic [ROW_W-1:0] scan_r;
    logic [FW-1:0]    frame_cnt;

    // Engine state
    upd_state_t       state, state_nx;
    logic [3:0]       rd_k;      // engine reads granted so far (9 per generation)
    logic [3:0]       cons_k;    // engine read results consumed so far
    logic             eng_rvalid;
    row_t             prev_q, cur_q, orig0_q;

    logic             disp_rd, slot_end, frame_end, frame_trig, trigger;
    logic             eng_req, eng_grant, row_wr, load_acc;
    logic [ROW_W-1:0] eng_addr, wr_addr;
    row_t             below, rule_next;

    assign disp_rd    = (dcnt == '0);
    assign slot_end   = (dcnt == DWELL_LAST);
    assign frame_end  = slot_end && (scan_r == '1);
    assign frame_trig = run && frame_end && (frame_cnt == FRAME_LAST);
    assign trigger    = (state == U_IDLE) && (step || frame_trig);

    // Read sequence is row 7, then rows 0..7, so the address is rd_k-1 mod 8.
    assign eng_req   = ((state == U_PRE) || (state == U_ROW)) && (rd_k < 4'd9);
    assign eng_addr  = rd_k[2:0] - 3'd1;
    assign eng_grant = eng_req && !disp_rd;
    assign mem_raddr = disp_rd ? scan_r : eng_addr;

    // Result k (k>=2) carries row k-1, which is "below" for row k-2; once all
    // nine reads are consumed, row 7 is finished using the saved original row 0.
    assign below   = (cons_k == 4'd9) ? orig0_q : mem_rdata;
    assign wr_addr = cons_k[2:0] - 3'd2;
    assign row_wr  = (state == U_ROW) && (eng_rvalid || (cons_k == 4'd9));

    cgol_row_rule u_rule (
        .prev  (prev_q),
        .cur   (cur_q),
        .below (below),
        .next  (rule_next)
    );

    // Display scanner: slot timing, row/col capture and frame counting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dcnt      <= '0;
            scan_r    <= '0;
            frame_cnt <= '0;
            row       <= '0;
            col       <= '0;
        end else begin
            dcnt <= slot_end ? '0 : dcnt + 1'b1;
            if (slot_end)
                scan_r <= scan_r + 1'b1;
            if (dcnt == DW'(1)) begin
                row <= row_t'(1) << scan_r;
                col <= mem_rdata;
            end
            if (trigger)
                frame_cnt <= '0;
            else if (frame_end)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Update engine registers: state, read/consume counters and row window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= U_IDLE;
            rd_k       <= '0;
            cons_k     <= '0;
            eng_rvalid <= 1'b0;
            prev_q     <= '0;
            cur_q      <= '0;
            orig0_q    <= '0;
            gen_count  <= '0;
        end else begin
            state      <= state_nx;
            eng_rvalid <= eng_grant;
            if (trigger) begin
                rd_k   <= '0;
                cons_k <= '0;
            end else begin
                if (eng_grant)
                    rd_k <= rd_k + 4'd1;
                if (eng_rvalid) begin
                    cons_k <= cons_k + 4'd1;
                    if (cons_k == 4'd0) begin
                        prev_q <= mem_rdata;
                    end else if (cons_k == 4'd1) begin
                        cur_q   <= mem_rdata;
                        orig0_q <= mem_rdata;
                    end else begin
                        prev_q <= cur_q;
                        cur_q  <= mem_rdata;
                    end
                end
            end
            if (state == U_DONE)
                gen_count <= gen_count + 16'd1;
        end
    end

    // Next-state logic and the shared write port / load handshake.
    always_comb begin
        state_nx   = state;
        busy       = (state != U_IDLE);
        load_ready = (state == U_IDLE) && !trigger;
        load_acc   = load_valid && load_ready;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
            U_IDLE: if (trigger) state_nx = U_PRE;
            U_PRE:  if (eng_rvalid && (cons_k == 4'd1)) state_nx = U_ROW;
            U_ROW:  if (cons_k == 4'd9) state_nx = U_DONE;
            U_DONE: state_nx = U_IDLE;
        endcase
        if (row_wr) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = rule_next;
        end else if (load_acc) begin
            mem_we    = 1'b1;
            mem_waddr = load_row;
            mem_wdata = load_data;
        end
    end

endmodule

// File: tb/tb_cgol_gen_sched.sv
// Self-checking bench for cgol_gen_sched: owns the board memory, keeps a
// cycle-level behavioural model of the controller and compares every cycle.
module tb_cgol_gen_sched;

    localparam int D   = 4;
    localparam int FPG = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        load_valid = 1'b0;
    logic [2:0]  load_row = '0;
    logic [7:0]  load_data = '0;
    logic        load_ready;
    logic [2:0]  mem_raddr;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic [2:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        busy;
    logic [15:0] gen_count;

    cgol_gen_sched #(.DWELL(D), .FRAMES_PER_GEN(FPG)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .load_valid (load_valid),
        .load_row   (load_row),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .row        (row),
        .col        (col),
        .busy       (busy),
        .gen_count  (gen_count)
    );

    always #5 clk = ~clk;

    // Board memory: synchronous write, registered read returning old data.
    logic [7:0] mem [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [63:0] mem_board();
        logic [63:0] x;
        for (int r = 0; r < 8; r++) x[r*8 +: 8] = mem[r];
        return x;
    endfunction

    // Toroidal Life on a packed board, bit (r*8+c) = cell at row r, column c.
    function automatic logic [63:0] life(input logic [63:0] b);
        logic [63:0] nb;
        int n;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(b[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
                nb[r*8 + c] = (n == 3) || (b[r*8 + c] && n == 2);
            end
        return nb;
    endfunction

    // ---------------- behavioural model ----------------
    bit          started = 0;
    int          ph = 0;          // cycles since reset release (scanner time)
    bit          mbusy = 0;
    int          reads_left = 0;  // engine reads still to be granted
    int          tail = 0;        // busy cycles left after the last read
    logic [15:0] mgen = '0;
    int          fc = 0;
    logic [63:0] mboard = '0;
    bit          chk_board = 0;
    logic [7:0]  exp_row = '0, exp_col = '0, pend = '0;

    function automatic bit is_frame_end(input int p);
        return (p % D == D - 1) && ((p / D) % 8 == 7);
    endfunction

    function automatic bit m_trig();
        return !mbusy && (step || (run && is_frame_end(ph) && fc == FPG - 1));
    endfunction

    // Advance the model by one clock edge using this cycle's inputs.
    always @(posedge clk) begin
        bit trig;
        started = 1;
        if (!reset) begin
            ph = 0; mbusy = 0; reads_left = 0; tail = 0;
            mgen = '0; fc = 0; exp_row = '0; exp_col = '0;
        end else begin
            trig = m_trig();
            if (!mbusy && load_valid && !trig)
                mboard[load_row*8 +: 8] = load_data;
            if (mbusy) begin
                if (reads_left > 0) begin
                    if (ph % D != 0) begin
                        reads_left--;
                        if (reads_left == 0) tail = 3;
                    end
                end else begin
                    tail--;
                    if (tail == 0) begin
                        mbusy = 0;
                        mgen = mgen + 16'd1;
                        mboard = life(mboard);
                        chk_board = 1;
                    end
                end
            end
            if (trig) begin
                mbusy = 1;
                reads_left = 9;
            end
            if (trig) fc = 0;
            else if (is_frame_end(ph)) fc = (fc == FPG - 1) ? 0 : fc + 1;
            ph++;
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        bit exp_lr, exp_we;
        if (started) begin
            if (ph % D == 0) pend = mem[(ph / D) % 8];
            if (ph >= 2 && (ph - 2) % D == 0) begin
                exp_row = 8'd1 << (((ph - 2) / D) % 8);
                exp_col = pend;
            end
            exp_lr = !mbusy && !m_trig();
            chk("busy", busy, mbusy);
            chk("gen_count", gen_count, mgen);
            chk("row", row, exp_row);
            chk("col", col, exp_col);
            chk("load_ready", load_ready, exp_lr);
            if (!mbusy) begin
                exp_we = load_valid && exp_lr;
                chk("mem_we", mem_we, exp_we);
                if (exp_we) begin
                    chk("mem_waddr", mem_waddr, load_row);
                    chk("mem_wdata", mem_wdata, load_data);
                end
            end
            if (chk_board) begin
                chk("board", mem_board(), mboard);
                chk_board = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc(); step = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] r, input logic [7:0] d);
        bit ok = 0;
        load_row = r; load_data = d; load_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = load_ready;
            cyc();
        end
        load_valid = 1'b0;
        chk("load_accepted", ok, 1'b1);
    endtask

    task automatic load_board(input logic [63:0] b);
        for (int r = 0; r < 8; r++) do_load(3'(r), b[r*8 +: 8]);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin @(negedge clk); k++; end
        chk("idle_within_bound", k < 300, 1'b1);
        cyc();
    endtask

    task automatic wait_row(input logic [7:0] want);
        int k = 0;
        @(negedge clk);
        while (row != want && k < 100) begin @(negedge clk); k++; end
        chk("row_seen", row, want);
    endtask

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] WRAP_BLOCK = 64'h8100_0000_0000_0081;

    initial begin
        logic [63:0] b;
        int d;

        // Reset and scanner start-up
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_row", row, 8'h00);
        chk("rst_col", col, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gen", gen_count, 16'h0);
        chk("rst_load_ready", load_ready, 1'b1);
        for (int t = 1; t < 34; t++) begin
            @(negedge clk);
            if (t >= 2) chk("scan_row", row, 8'd1 << (((t - 2) / D) % 8));
        end
        cyc();

        // Display-only: row 5 loaded, no updates
        do_load(3'd5, 8'hA5);
        wait_row(8'h20);
        chk("row5_col", col, 8'hA5);
        wait_row(8'h01);
        chk("row0_col", col, 8'h00);
        chk("no_update_gen", gen_count, 16'd0);
        cyc();

        // Blinker, single steps
        load_board(BLINK_H);
        pulse_step();
        wait_idle();
        chk("blinker_gen1", mem_board(), BLINK_V);
        chk("gen_1", gen_count, 16'd1);
        pulse_step();
        wait_idle();
        chk("blinker_gen2", mem_board(), BLINK_H);
        chk("gen_2", gen_count, 16'd2);

        // Still-life block across row and column wrap
        load_board(WRAP_BLOCK);
        pulse_step();
        wait_idle();
        chk("wrap_block", mem_board(), WRAP_BLOCK);
        chk("gen_3", gen_count, 16'd3);

        // Random boards, stray steps and loads while busy
        for (int it = 0; it < 6; it++) begin
            b = {$urandom, $urandom};
            load_board(b);
            pulse_step();
            d = $urandom_range(1, 6);
            repeat (d) cyc();
            if ($urandom_range(0, 1) == 1) pulse_step();
            if ($urandom_range(0, 1) == 1) do_load(3'($urandom_range(0, 7)), 8'($urandom));
            wait_idle();
        end
        chk("gen_9", gen_count, 16'd9);

        // Step and load while busy
        load_board(BLINK_H);
        pulse_step();
        repeat (3) cyc();
        pulse_step();
        do_load(3'd0, 8'h00);
        wait_idle();
        chk("busy_step_ignored_gen", gen_count, 16'd10);
        chk("busy_step_board", mem_board(), BLINK_V);

        // Reset in the middle of an update
        pulse_step();
        repeat (6) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_gen", gen_count, 16'd0);
        cyc();
        @(negedge clk);
        chk("midrst_idle", busy, 1'b0);
        cyc();

        // Free-running generations
        load_board(BLINK_H);
        run = 1'b1;
        repeat (330) cyc();
        run = 1'b0;
        wait_idle();
        chk("run_gens", gen_count >= 16'd4, 1'b1);
        chk("run_period2", (mem_board() == BLINK_H) || (mem_board() == BLINK_V), 1'b1);
        repeat (10) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
